// File: rtl/dcache_pkg.sv
// Shared types and default geometry for the direct-mapped write-back data cache.
package dcache_pkg;
    localparam int ADDR_W         = 32;
    localparam int WORD_W         = 32;
    localparam int DEF_NUM_SETS   = 16;
    localparam int DEF_LINE_BYTES = 16;
    localparam int DEF_OFF_W      = $clog2(DEF_LINE_BYTES);
    localparam int DEF_IDX_W      = $clog2(DEF_NUM_SETS);
    localparam int DEF_TAG_W      = ADDR_W - DEF_IDX_W - DEF_OFF_W;
    localparam int DEF_WOFF_W     = DEF_OFF_W - 2;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_COMPARE   = 2'd1,
        ST_WRITEBACK = 2'd2,
        ST_ALLOCATE  = 2'd3
    } state_t;
endpackage

// File: rtl/dcache_line_array.sv
// Tag/valid/dirty/data storage: one combinational read port, one write port.
// Valid/dirty reset asynchronously; tag and data arrays are not reset.
module dcache_line_array #(
    parameter int NUM_SETS = 16,
    parameter int IDX_W    = 4,
    parameter int TAG_W    = 24,
    parameter int LINE_W   = 128
)(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [IDX_W-1:0]  i_rd_idx,
    output logic              o_rd_valid,
    output logic              o_rd_dirty,
    output logic [TAG_W-1:0]  o_rd_tag,
    output logic [LINE_W-1:0] o_rd_data,
    input  logic              i_wr_en,
    input  logic [IDX_W-1:0]  i_wr_idx,
    input  logic [TAG_W-1:0]  i_wr_tag,
    input  logic [LINE_W-1:0] i_wr_data,
    input  logic              i_wr_valid,
    input  logic              i_wr_dirty
);
    logic [NUM_SETS-1:0] r_valid;
    logic [NUM_SETS-1:0] r_dirty;
    logic [TAG_W-1:0]    r_tag  [NUM_SETS];
    logic [LINE_W-1:0]   r_data [NUM_SETS];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (i_wr_en) begin
            r_valid[i_wr_idx] <= i_wr_valid;
            r_dirty[i_wr_idx] <= i_wr_dirty;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_tag[i_wr_idx]  <= i_wr_tag;
            r_data[i_wr_idx] <= i_wr_data;
        end
    end

    assign o_rd_valid = r_valid[i_rd_idx];
    assign o_rd_dirty = r_dirty[i_rd_idx];
    assign o_rd_tag   = r_tag[i_rd_idx];
    assign o_rd_data  = r_data[i_rd_idx];
endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-back/write-allocate data cache with a line-wide memory port.
// Define DCACHE_STATS_EN to build the hit/miss counters; otherwise they read 0.
module data_cache
    import dcache_pkg::*;
#(
    parameter int NUM_SETS   = DEF_NUM_SETS,
    parameter int LINE_BYTES = DEF_LINE_BYTES
)(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    is_input_valid,
    input  logic [31:0]             addr,
    input  logic                    mem_rw,
    input  logic [31:0]             din,
    output logic                    is_ready,
    output logic                    is_output_valid,
    output logic [31:0]             dout,
    output logic                    is_hit,
    output logic                    mem_req_valid,
    input  logic                    mem_req_ready,
    output logic                    mem_req_write,
    output logic [31:0]             mem_req_addr,
    output logic [LINE_BYTES*8-1:0] mem_req_data,
    input  logic                    mem_resp_valid,
    input  logic [LINE_BYTES*8-1:0] mem_resp_data,
    output logic [31:0]             hit_count,
    output logic [31:0]             miss_count
);
    localparam int OFF_W  = $clog2(LINE_BYTES);
    localparam int IDX_W  = $clog2(NUM_SETS);
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
    localparam int WORDS  = LINE_BYTES / 4;
    localparam int WOFF_W = OFF_W - 2;
    localparam int LINE_W = LINE_BYTES * 8;

    state_t              r_state;
    logic [TAG_W-1:0]    r_tag;
    logic [IDX_W-1:0]    r_idx;
    logic [WOFF_W-1:0]   r_woff;
    logic                r_rw;
    logic [31:0]         r_din;
    logic                r_first;
    logic                r_mreq_valid;
    logic                r_mreq_write;
    logic [31:0]         r_mreq_addr;
    logic [LINE_W-1:0]   r_mreq_data;

    logic                w_rd_valid;
    logic                w_rd_dirty;
    logic [TAG_W-1:0]    w_rd_tag;
    logic [LINE_W-1:0]   w_rd_data;
    logic [WORDS-1:0][31:0] w_words;
    logic [WORDS-1:0][31:0] w_merged;
    logic                w_tag_match;
    logic                w_hit;
    logic                w_fill;
    logic                w_wr_en;
    logic [LINE_W-1:0]   w_wr_data;
    logic                w_unused;

    assign w_unused = ^addr[1:0];

    dcache_line_array #(
        .NUM_SETS (NUM_SETS),
        .IDX_W    (IDX_W),
        .TAG_W    (TAG_W),
        .LINE_W   (LINE_W)
    ) u_lines (
        .i_clk      (clk),
        .i_rst_n    (reset),
        .i_rd_idx   (r_idx),
        .o_rd_valid (w_rd_valid),
        .o_rd_dirty (w_rd_dirty),
        .o_rd_tag   (w_rd_tag),
        .o_rd_data  (w_rd_data),
        .i_wr_en    (w_wr_en),
        .i_wr_idx   (r_idx),
        .i_wr_tag   (r_tag),
        .i_wr_data  (w_wr_data),
        .i_wr_valid (1'b1),
        .i_wr_dirty (!w_fill)
    );

    assign w_words     = w_rd_data;
    assign w_tag_match = w_rd_valid && (w_rd_tag == r_tag);
    assign w_hit       = (r_state == ST_COMPARE) && w_tag_match;
    // A fill is only taken once the read request has been handed off.
    assign w_fill      = (r_state == ST_ALLOCATE) && !r_mreq_valid && mem_resp_valid;
    assign w_wr_en     = (w_hit && r_rw) || w_fill;

    always_comb begin
        w_merged         = w_words;
        w_merged[r_woff] = r_din;
    end

    assign w_wr_data = w_fill ? mem_resp_data : LINE_W'(w_merged);

    assign is_ready        = (r_state == ST_IDLE);
    assign is_output_valid = w_hit;
    assign dout            = w_hit ? w_words[r_woff] : 32'd0;
    assign is_hit          = w_hit && r_first;
    assign mem_req_valid   = r_mreq_valid;
    assign mem_req_write   = r_mreq_write;
    assign mem_req_addr    = r_mreq_addr;
    assign mem_req_data    = r_mreq_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_tag        <= '0;
            r_idx        <= '0;
            r_woff       <= '0;
            r_rw         <= 1'b0;
            r_din        <= '0;
            r_first      <= 1'b0;
            r_mreq_valid <= 1'b0;
            r_mreq_write <= 1'b0;
            r_mreq_addr  <= '0;
            r_mreq_data  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (is_input_valid) begin
                        r_tag   <= addr[31 -: TAG_W];
                        r_idx   <= addr[OFF_W +: IDX_W];
                        r_woff  <= addr[2 +: WOFF_W];
                        r_rw    <= mem_rw;
                        r_din   <= din;
                        r_first <= 1'b1;
                        r_state <= ST_COMPARE;
                    end
                end
                ST_COMPARE: begin
                    if (w_tag_match) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_first      <= 1'b0;
                        r_mreq_valid <= 1'b1;
                        if (w_rd_valid && w_rd_dirty) begin
                            r_mreq_write <= 1'b1;
                            r_mreq_addr  <= {w_rd_tag, r_idx, {OFF_W{1'b0}}};
                            r_mreq_data  <= w_rd_data;
                            r_state      <= ST_WRITEBACK;
                        end else begin
                            r_mreq_write <= 1'b0;
                            r_mreq_addr  <= {r_tag, r_idx, {OFF_W{1'b0}}};
                            r_state      <= ST_ALLOCATE;
                        end
                    end
                end
                ST_WRITEBACK: begin
                    // Victim accepted: reuse the still-asserted valid for the fill request.
                    if (mem_req_ready) begin
                        r_mreq_write <= 1'b0;
                        r_mreq_addr  <= {r_tag, r_idx, {OFF_W{1'b0}}};
                        r_state      <= ST_ALLOCATE;
                    end
                end
                ST_ALLOCATE: begin
                    if (r_mreq_valid) begin
                        if (mem_req_ready) r_mreq_valid <= 1'b0;
                    end else if (mem_resp_valid) begin
                        r_state <= ST_COMPARE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (r_state == ST_COMPARE && r_first) begin
            if (w_tag_match) r_hit_cnt  <= r_hit_cnt + 32'd1;
            else             r_miss_cnt <= r_miss_cnt + 32'd1;
        end
    end

    assign hit_count  = r_hit_cnt;
    assign miss_count = r_miss_cnt;
`else
    assign hit_count  = 32'd0;
    assign miss_count = 32'd0;
`endif
endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache: miss/hit/write-back/back-pressure/reset scenarios
// against a small line-addressed backing memory.
module tb_data_cache;
    logic         clk;
    logic         reset;
    logic         is_input_valid;
    logic [31:0]  addr;
    logic         mem_rw;
    logic [31:0]  din;
    logic         is_ready;
    logic         is_output_valid;
    logic [31:0]  dout;
    logic         is_hit;
    logic         mem_req_valid;
    logic         mem_req_ready;
    logic         mem_req_write;
    logic [31:0]  mem_req_addr;
    logic [127:0] mem_req_data;
    logic         mem_resp_valid;
    logic [127:0] mem_resp_data;
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;

    data_cache dut (
        .clk            (clk),
        .reset          (reset),
        .is_input_valid (is_input_valid),
        .addr           (addr),
        .mem_rw         (mem_rw),
        .din            (din),
        .is_ready       (is_ready),
        .is_output_valid(is_output_valid),
        .dout           (dout),
        .is_hit         (is_hit),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_write  (mem_req_write),
        .mem_req_addr   (mem_req_addr),
        .mem_req_data   (mem_req_data),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .hit_count      (hit_count),
        .miss_count     (miss_count)
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic [127:0] mem [logic [31:0]];
    logic [31:0]  q_addr [$];
    logic         q_wr   [$];
    logic [127:0] q_data [$];
    int           stall_left = 0;
    logic         rd_pending = 0;
    logic [127:0] rd_data_pend;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Backing memory: raises ready for one cycle per request, answers reads the
    // cycle after the handshake.
    initial begin
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        forever begin
            @(negedge clk);
            mem_resp_valid = 1'b0;
            if (!reset) begin
                mem_req_ready = 1'b0;
                rd_pending    = 1'b0;
            end else if (mem_req_ready) begin
                mem_req_ready = 1'b0;
                if (rd_pending) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_data  = rd_data_pend;
                end
                rd_pending = 1'b0;
            end else if (mem_req_valid) begin
                if (stall_left > 0) begin
                    stall_left--;
                end else begin
                    mem_req_ready = 1'b1;
                    q_addr.push_back(mem_req_addr);
                    q_wr.push_back(mem_req_write);
                    q_data.push_back(mem_req_data);
                    if (mem_req_write) begin
                        mem[mem_req_addr] = mem_req_data;
                    end else begin
                        rd_pending   = 1'b1;
                        rd_data_pend = mem.exists(mem_req_addr) ? mem[mem_req_addr] : '0;
                    end
                end
            end
        end
    end

    task automatic access(input logic rw, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rdata, output logic hit,
                          output int lat, output logic saw_req);
        int n;
        rdata   = '0;
        hit     = 1'b0;
        saw_req = 1'b0;
        @(negedge clk);
        n = 0;
        while (!is_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        is_input_valid = 1'b1;
        addr           = a;
        mem_rw         = rw;
        din            = d;
        @(negedge clk);
        is_input_valid = 1'b0;
        lat = 1;
        while (!is_output_valid && lat < 200) begin
            if (mem_req_valid) saw_req = 1'b1;
            @(negedge clk);
            lat++;
        end
        check("access_done", is_output_valid, 1'b1);
        rdata = dout;
        hit   = is_hit;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0]  rd;
        logic         h;
        int           lat;
        logic         sreq;
        logic [31:0]  exp_hits;
        logic [31:0]  exp_miss;
        logic [31:0]  s_addr;
        logic         s_wr;
        logic         stable;
        logic         busy;
        logic         stray;
        int           n;

`ifdef DCACHE_STATS_EN
        exp_hits = 32'd2;
        exp_miss = 32'd2;
`else
        exp_hits = 32'd0;
        exp_miss = 32'd0;
`endif

        mem[32'h0000_0040] = {4{32'h1111_1111}};
        mem[32'h0000_0140] = {4{32'h2222_2222}};
        mem[32'h0000_0240] = {4{32'h3333_3333}};

        reset = 1'b0; is_input_valid = 1'b0; addr = '0; mem_rw = 1'b0; din = '0;
        repeat (3) @(negedge clk);
        check("rst_ready",     is_ready,        1'b1);
        check("rst_out_valid", is_output_valid, 1'b0);
        check("rst_hit",       is_hit,          1'b0);
        check("rst_dout",      dout,            32'd0);
        check("rst_mreq",      mem_req_valid,   1'b0);
        check("rst_mwrite",    mem_req_write,   1'b0);
        check("rst_hitcnt",    hit_count,       32'd0);
        check("rst_misscnt",   miss_count,      32'd0);
        reset = 1'b1;

        // Cold miss on 0x40
        q_addr.delete(); q_wr.delete(); q_data.delete();
        access(1'b0, 32'h0000_0040, 32'd0, rd, h, lat, sreq);
        check("miss_dout",  rd,            32'h1111_1111);
        check("miss_hit",   h,             1'b0);
        check("miss_nreq",  q_addr.size(), 1);
        check("miss_raddr", q_addr[0],     32'h0000_0040);
        check("miss_rwr",   q_wr[0],       1'b0);

        // Hit on another word of the same line
        q_addr.delete(); q_wr.delete(); q_data.delete();
        access(1'b0, 32'h0000_0044, 32'd0, rd, h, lat, sreq);
        check("hit_dout", rd,            32'h1111_1111);
        check("hit_hit",  h,             1'b1);
        check("hit_lat",  lat,           1);
        check("hit_nreq", q_addr.size(), 0);
        check("hit_sreq", sreq,          1'b0);

        // Store hit, then conflicting load forces write-back
        access(1'b1, 32'h0000_0040, 32'hDEAD_BEEF, rd, h, lat, sreq);
        check("st_hit", h,   1'b1);
        check("st_lat", lat, 1);
        q_addr.delete(); q_wr.delete(); q_data.delete();
        access(1'b0, 32'h0000_0140, 32'd0, rd, h, lat, sreq);
        check("wb_dout",   rd,            32'h2222_2222);
        check("wb_hit",    h,             1'b0);
        check("wb_nreq",   q_addr.size(), 2);
        check("wb_wr0",    q_wr[0],       1'b1);
        check("wb_addr0",  q_addr[0],     32'h0000_0040);
        check("wb_data0",  q_data[0],     128'h1111_1111_1111_1111_1111_1111_DEAD_BEEF);
        check("wb_wr1",    q_wr[1],       1'b0);
        check("wb_addr1",  q_addr[1],     32'h0000_0140);
        check("stat_hits", hit_count,     exp_hits);
        check("stat_miss", miss_count,    exp_miss);

        // Back-pressure: memory withholds ready, CPU keeps knocking
        q_addr.delete(); q_wr.delete(); q_data.delete();
        stall_left = 6;
        @(negedge clk);
        is_input_valid = 1'b1; addr = 32'h0000_0240; mem_rw = 1'b0; din = '0;
        @(negedge clk);
        is_input_valid = 1'b0;
        n = 0;
        while (!mem_req_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("hold_req_seen", mem_req_valid, 1'b1);
        s_addr = mem_req_addr;
        s_wr   = mem_req_write;
        stable = 1'b1;
        busy   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            is_input_valid = 1'b1; addr = 32'h0000_0080; mem_rw = 1'b1; din = 32'hBAD0_0000;
            if (mem_req_valid !== 1'b1 || mem_req_addr !== s_addr || mem_req_write !== s_wr)
                stable = 1'b0;
            if (is_ready !== 1'b0) busy = 1'b0;
        end
        is_input_valid = 1'b0;
        check("hold_addr",   s_addr, 32'h0000_0240);
        check("hold_stable", stable, 1'b1);
        check("hold_busy",   busy,   1'b1);
        n = 0;
        while (!is_output_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("hold_done", is_output_valid, 1'b1);
        check("hold_dout", dout,            32'h3333_3333);
        check("hold_nreq", q_addr.size(),   1);
        stray = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (is_output_valid || mem_req_valid) stray = 1'b1;
        end
        check("hold_ignored", stray, 1'b0);

        // Reset while a fill request is outstanding
        stall_left = 1000;
        @(negedge clk);
        is_input_valid = 1'b1; addr = 32'h0000_0080; mem_rw = 1'b0;
        @(negedge clk);
        is_input_valid = 1'b0;
        n = 0;
        while (!mem_req_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rmid_req", mem_req_valid, 1'b1);
        check("rmid_busy", is_ready,     1'b0);
        reset = 1'b0;
        #1;
        check("rmid_mreq",    mem_req_valid, 1'b0);
        check("rmid_ready",   is_ready,      1'b1);
        check("rmid_hitcnt",  hit_count,     32'd0);
        check("rmid_misscnt", miss_count,    32'd0);
        stall_left = 0;
        @(negedge clk);
        reset = 1'b1;
        q_addr.delete(); q_wr.delete(); q_data.delete();
        access(1'b0, 32'h0000_0040, 32'd0, rd, h, lat, sreq);
        check("rl_hit",   h,             1'b0);
        check("rl_dout",  rd,            32'hDEAD_BEEF);
        check("rl_nreq",  q_addr.size(), 1);
        check("rl_raddr", q_addr[0],     32'h0000_0040);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
